// File: rtl/vram_arbiter_if.sv
// Purpose: bundles the VGA fetch, CPU window and RAM port signals of the video RAM arbiter.
// Latency: none, wiring only.
// Backpressure: none here; the CPU side is a req/ack level handshake and the VGA side is strobe-only.
interface vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    // VGA fetcher side
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;
    logic              vga_overrun;

    // CPU window side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_ack;

    // Synchronous-read RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // Arbiter view: takes requests and RAM read data, drives everything else
    modport slave (
        input  vga_req, vga_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  ram_dout,
        output vga_data, vga_valid, vga_overrun,
        output cpu_dout, cpu_ack,
        output ram_addr, ram_we, ram_din
    );

    // Client view: VGA generator, CPU bus and RAM instance together
    modport master (
        output vga_req, vga_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output ram_dout,
        input  vga_data, vga_valid, vga_overrun,
        input  cpu_dout, cpu_ack,
        input  ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/vram_arbiter.sv
// Purpose: shares one synchronous-read video RAM between VGA fetches (absolute priority) and the CPU window.
// Latency: 3 cycles from an idle grant to vga_valid/cpu_ack; a VGA strobe colliding with a CPU access adds 1.
// Backpressure: CPU waits on cpu_ack; VGA cannot be stalled, one colliding strobe is latched, extras set overrun.
module vram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

    state_t            state_q;
    state_t            state_d;
    owner_t            own_q;
    owner_t            own_d;

    logic              pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              ovr_q;
    logic              lock_q;
    logic              wr_q;

    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_din_q;
    logic [DATA_W-1:0] vga_data_q;
    logic              vga_valid_q;
    logic [DATA_W-1:0] cpu_dout_q;
    logic              cpu_ack_q;

    logic              grant_pt;
    logic              cpu_done;
    logic              cpu_elig;
    logic              grant_vga;
    logic              grant_cpu;
    logic [ADDR_W-1:0] vga_gaddr;

    // Grant decision: VGA (latched or fresh) beats CPU; the CPU access finishing now is not re-eligible
    always_comb begin
        grant_pt  = (state_q == IDLE) || (state_q == CAPTURE);
        cpu_done  = (state_q == CAPTURE) && (own_q == OWN_CPU);
        cpu_elig  = bus.cpu_req && !lock_q && !cpu_done;
        grant_vga = grant_pt && (pend_q || bus.vga_req);
        grant_cpu = grant_pt && !grant_vga && cpu_elig;
        // A fresh strobe at a grant point supersedes a latched one
        vga_gaddr = bus.vga_req ? bus.vga_addr : pend_addr_q;
    end

    // Next-state and owner selection
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        case (state_q)
            IDLE, CAPTURE: begin
                if (grant_vga) begin
                    state_d = ISSUE;
                    own_d   = OWN_VGA;
                end else if (grant_cpu) begin
                    state_d = ISSUE;
                    own_d   = OWN_CPU;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and owner registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            own_q   <= OWN_VGA;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
        end
    end

    // VGA pending latch and sticky overrun flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            ovr_q       <= 1'b0;
        end else begin
            // A strobe while one is already latched loses the older request
            if (bus.vga_req && pend_q) begin
                ovr_q <= 1'b1;
            end
            if (grant_vga) begin
                pend_q <= 1'b0;
            end else if (bus.vga_req) begin
                pend_q      <= 1'b1;
                pend_addr_q <= bus.vga_addr;
            end
        end
    end

    // RAM request registers; write enable is a single ISSUE-cycle pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
            wr_q       <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            if (grant_vga) begin
                ram_addr_q <= vga_gaddr;
            end else if (grant_cpu) begin
                ram_addr_q <= bus.cpu_addr;
                ram_we_q   <= bus.cpu_we;
                ram_din_q  <= bus.cpu_din;
                wr_q       <= bus.cpu_we;
            end
        end
    end

    // Result capture, completion pulses and CPU re-request lock
    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_data_q  <= '0;
            vga_valid_q <= 1'b0;
            cpu_dout_q  <= '0;
            cpu_ack_q   <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            vga_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            if (state_q == CAPTURE) begin
                if (own_q == OWN_VGA) begin
                    vga_data_q  <= bus.ram_dout;
                    vga_valid_q <= 1'b1;
                end else begin
                    if (!wr_q) begin
                        cpu_dout_q <= bus.ram_dout;
                    end
                    cpu_ack_q <= 1'b1;
                end
            end
            // Lock until the CPU drops its request so a held req is served once
            if (cpu_done) begin
                lock_q <= 1'b1;
            end else if (!bus.cpu_req) begin
                lock_q <= 1'b0;
            end
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_din     = ram_din_q;
    assign bus.vga_data    = vga_data_q;
    assign bus.vga_valid   = vga_valid_q;
    assign bus.vga_overrun = ovr_q;
    assign bus.cpu_dout    = cpu_dout_q;
    assign bus.cpu_ack     = cpu_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Purpose: directed vectors and short hand-written sequences for vram_arbiter against an 8 KB RAM model.
// Latency: inputs change 1 time unit after a rising edge; outputs are checked 1 time unit after the next one.
// Backpressure: the bench plays both the VGA generator and a CPU that holds cpu_req until cpu_ack.
module tb_vram_arbiter;

    logic clk;
    logic reset;

    vram_arbiter_if bus ();

    vram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: synchronous read, write on ram_we; contents preloaded on the first edge
    logic [7:0] mem [0:8191];
    bit         ram_init;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
            mem[13'h0123] <= 8'h5A;
            mem[13'h0040] <= 8'h11;
            mem[13'h0041] <= 8'h22;
            mem[13'h0200] <= 8'h33;
            mem[13'h0300] <= 8'h44;
            mem[13'h0301] <= 8'h55;
            ram_init <= 1'b1;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    // vga_valid and cpu_ack must never coincide
    int both_cnt;
    always @(negedge clk) begin
        if (bus.vga_valid && bus.cpu_ack) both_cnt++;
    end

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic        vreq;
        logic [12:0] vaddr;
        logic        creq;
        logic        cwe;
        logic [12:0] caddr;
        logic [7:0]  cdin;
        logic [12:0] e_raddr;
        logic        e_rwe;
        logic [7:0]  e_rdin;
        logic        e_vvld;
        logic [7:0]  e_vdat;
        logic        e_ovr;
        logic        e_ack;
        logic [7:0]  e_cdout;
    } vec_t;

    vec_t vt [25];

    function automatic vec_t mk(logic r, logic vr, logic [12:0] va, logic cr, logic cw, logic [12:0] ca,
                                logic [7:0] cd, logic [12:0] ra, logic rw, logic [7:0] rd, logic vv,
                                logic [7:0] vd, logic ov, logic ak, logic [7:0] co);
        vec_t v;
        v.rst = r; v.vreq = vr; v.vaddr = va; v.creq = cr; v.cwe = cw; v.caddr = ca; v.cdin = cd;
        v.e_raddr = ra; v.e_rwe = rw; v.e_rdin = rd; v.e_vvld = vv; v.e_vdat = vd;
        v.e_ovr = ov; v.e_ack = ak; v.e_cdout = co;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then step to 1 time unit past the next rising edge
    task automatic cyc(input logic r, input logic vr, input logic [12:0] va, input logic cr,
                       input logic cw, input logic [12:0] ca, input logic [7:0] cd);
        reset        = r;
        bus.vga_req  = vr;
        bus.vga_addr = va;
        bus.cpu_req  = cr;
        bus.cpu_we   = cw;
        bus.cpu_addr = ca;
        bus.cpu_din  = cd;
        @(posedge clk);
        #1;
    endtask

    // CPU read from IDLE: bounded wait for cpu_ack, then latency and data checks, then release
    task automatic cpu_read(input logic [12:0] addr, input logic [7:0] exp, input string name);
        int lat;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 13'h0, 1'b1, 1'b0, addr, 8'h00);
            lat++;
            if (bus.cpu_ack) break;
        end
        chk({name, ".ack_latency"}, lat, 3);
        chk({name, ".cpu_dout"}, bus.cpu_dout, exp);
        cyc(1'b1, 1'b0, 13'h0, 1'b0, 1'b0, addr, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int vcnt;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;

        //            rst vr vaddr    cr cw caddr     cdin  | raddr     we din    vv vdat  ov ak cdout
        // reset held with a request present, then a CPU read of 0x0123
        vt[0]  = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        vt[1]  = mk(0, 0, 13'h0000, 1, 0, 13'h0123, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        vt[2]  = mk(1, 0, 13'h0000, 1, 0, 13'h0123, 8'h00, 13'h0123, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        vt[3]  = mk(1, 0, 13'h0000, 1, 0, 13'h0123, 8'h00, 13'h0123, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        vt[4]  = mk(1, 0, 13'h0000, 1, 0, 13'h0123, 8'h00, 13'h0123, 0, 8'h00, 0, 8'h00, 0, 1, 8'h5A);
        vt[5]  = mk(1, 0, 13'h0000, 0, 0, 13'h0123, 8'h00, 13'h0123, 0, 8'h00, 0, 8'h00, 0, 0, 8'h5A);
        // CPU write 0x1FFF <- 0xA5, request held 5 cycles past the ack
        vt[6]  = mk(1, 0, 13'h0000, 1, 1, 13'h1FFF, 8'hA5, 13'h1FFF, 1, 8'hA5, 0, 8'h00, 0, 0, 8'h5A);
        vt[7]  = mk(1, 0, 13'h0000, 1, 1, 13'h1FFF, 8'hA5, 13'h1FFF, 0, 8'hA5, 0, 8'h00, 0, 0, 8'h5A);
        vt[8]  = mk(1, 0, 13'h0000, 1, 1, 13'h1FFF, 8'hA5, 13'h1FFF, 0, 8'hA5, 0, 8'h00, 0, 1, 8'h5A);
        for (int i = 9; i < 14; i++)
            vt[i] = mk(1, 0, 13'h0000, 1, 1, 13'h1FFF, 8'hA5, 13'h1FFF, 0, 8'hA5, 0, 8'h00, 0, 0, 8'h5A);
        vt[14] = mk(1, 0, 13'h0000, 0, 0, 13'h1FFF, 8'hA5, 13'h1FFF, 0, 8'hA5, 0, 8'h00, 0, 0, 8'h5A);
        // simultaneous VGA 0x0040 and CPU read 0x0041: VGA first, CPU at the next grant point
        vt[15] = mk(1, 1, 13'h0040, 1, 0, 13'h0041, 8'h00, 13'h0040, 0, 8'hA5, 0, 8'h00, 0, 0, 8'h5A);
        vt[16] = mk(1, 0, 13'h0000, 1, 0, 13'h0041, 8'h00, 13'h0040, 0, 8'hA5, 0, 8'h00, 0, 0, 8'h5A);
        vt[17] = mk(1, 0, 13'h0000, 1, 0, 13'h0041, 8'h00, 13'h0041, 0, 8'h00, 1, 8'h11, 0, 0, 8'h5A);
        vt[18] = mk(1, 0, 13'h0000, 1, 0, 13'h0041, 8'h00, 13'h0041, 0, 8'h00, 0, 8'h11, 0, 0, 8'h5A);
        vt[19] = mk(1, 0, 13'h0000, 1, 0, 13'h0041, 8'h00, 13'h0041, 0, 8'h00, 0, 8'h11, 0, 1, 8'h22);
        vt[20] = mk(1, 0, 13'h0000, 0, 0, 13'h0041, 8'h00, 13'h0041, 0, 8'h00, 0, 8'h11, 0, 0, 8'h22);
        // read back 0x1FFF to confirm the write landed
        vt[21] = mk(1, 0, 13'h0000, 1, 0, 13'h1FFF, 8'h00, 13'h1FFF, 0, 8'h00, 0, 8'h11, 0, 0, 8'h22);
        vt[22] = mk(1, 0, 13'h0000, 1, 0, 13'h1FFF, 8'h00, 13'h1FFF, 0, 8'h00, 0, 8'h11, 0, 0, 8'h22);
        vt[23] = mk(1, 0, 13'h0000, 1, 0, 13'h1FFF, 8'h00, 13'h1FFF, 0, 8'h00, 0, 8'h11, 0, 1, 8'hA5);
        vt[24] = mk(1, 0, 13'h0000, 0, 0, 13'h1FFF, 8'h00, 13'h1FFF, 0, 8'h00, 0, 8'h11, 0, 0, 8'hA5);

        for (int i = 0; i < 25; i++) begin
            cyc(vt[i].rst, vt[i].vreq, vt[i].vaddr, vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].cdin);
            chk($sformatf("v%0d.ram_addr", i), bus.ram_addr, vt[i].e_raddr);
            chk($sformatf("v%0d.ram_we", i), bus.ram_we, vt[i].e_rwe);
            chk($sformatf("v%0d.ram_din", i), bus.ram_din, vt[i].e_rdin);
            chk($sformatf("v%0d.vga_valid", i), bus.vga_valid, vt[i].e_vvld);
            chk($sformatf("v%0d.vga_data", i), bus.vga_data, vt[i].e_vdat);
            chk($sformatf("v%0d.vga_overrun", i), bus.vga_overrun, vt[i].e_ovr);
            chk($sformatf("v%0d.cpu_ack", i), bus.cpu_ack, vt[i].e_ack);
            chk($sformatf("v%0d.cpu_dout", i), bus.cpu_dout, vt[i].e_cdout);
        end

        // VGA strobe one cycle after a CPU grant is latched and served after the CPU access
        cyc(1, 0, 13'h0000, 1, 0, 13'h0300, 8'h00);
        chk("pend.e0_ram_addr", bus.ram_addr, 13'h0300);
        cyc(1, 1, 13'h0200, 1, 0, 13'h0300, 8'h00);
        chk("pend.e1_ram_addr", bus.ram_addr, 13'h0300);
        chk("pend.e1_vga_valid", bus.vga_valid, 0);
        cyc(1, 0, 13'h0000, 1, 0, 13'h0300, 8'h00);
        chk("pend.e2_cpu_ack", bus.cpu_ack, 1);
        chk("pend.e2_cpu_dout", bus.cpu_dout, 8'h44);
        chk("pend.e2_ram_addr", bus.ram_addr, 13'h0200);
        cyc(1, 0, 13'h0000, 0, 0, 13'h0300, 8'h00);
        chk("pend.e3_vga_valid", bus.vga_valid, 0);
        cyc(1, 0, 13'h0000, 0, 0, 13'h0000, 8'h00);
        chk("pend.e4_vga_valid", bus.vga_valid, 1);
        chk("pend.e4_vga_data", bus.vga_data, 8'h33);
        chk("pend.e4_overrun", bus.vga_overrun, 0);
        cyc(1, 0, 13'h0000, 0, 0, 13'h0000, 8'h00);
        chk("pend.e5_vga_valid", bus.vga_valid, 0);

        // second strobe while the first is latched: overrun, newer address served, older lost
        cyc(1, 0, 13'h0000, 1, 0, 13'h0301, 8'h00);
        cyc(1, 1, 13'h0040, 1, 0, 13'h0301, 8'h00);
        chk("ovr.e1_overrun", bus.vga_overrun, 0);
        cyc(1, 1, 13'h0200, 1, 0, 13'h0301, 8'h00);
        chk("ovr.e2_overrun", bus.vga_overrun, 1);
        chk("ovr.e2_ram_addr", bus.ram_addr, 13'h0200);
        chk("ovr.e2_cpu_ack", bus.cpu_ack, 1);
        chk("ovr.e2_cpu_dout", bus.cpu_dout, 8'h55);
        cyc(1, 0, 13'h0000, 0, 0, 13'h0000, 8'h00);
        cyc(1, 0, 13'h0000, 0, 0, 13'h0000, 8'h00);
        chk("ovr.e4_vga_valid", bus.vga_valid, 1);
        chk("ovr.e4_vga_data", bus.vga_data, 8'h33);
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 13'h0000, 0, 0, 13'h0000, 8'h00);
            if (bus.vga_valid) vcnt++;
        end
        chk("ovr.no_extra_valid", vcnt, 0);
        chk("ovr.sticky", bus.vga_overrun, 1);
        cyc(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00);
        chk("ovr.reset_clears", bus.vga_overrun, 0);
        chk("ovr.reset_vga_data", bus.vga_data, 8'h00);
        cyc(1, 0, 13'h0000, 0, 0, 13'h0000, 8'h00);
        chk("ovr.after_reset", bus.vga_overrun, 0);

        // reset during CAPTURE of a CPU read abandons it; the re-presented request completes
        cpu_read(13'h0301, 8'h55, "rst.pre");
        cyc(1, 0, 13'h0000, 1, 0, 13'h0123, 8'h00);
        cyc(1, 0, 13'h0000, 1, 0, 13'h0123, 8'h00);
        cyc(0, 0, 13'h0000, 1, 0, 13'h0123, 8'h00);
        chk("rst.cap_cpu_ack", bus.cpu_ack, 0);
        chk("rst.cap_cpu_dout", bus.cpu_dout, 8'h00);
        chk("rst.cap_ram_addr", bus.ram_addr, 13'h0000);
        cyc(0, 0, 13'h0000, 1, 0, 13'h0123, 8'h00);
        chk("rst.held_cpu_ack", bus.cpu_ack, 0);
        cpu_read(13'h0123, 8'h5A, "rst.post");

        chk("excl.valid_ack", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
